// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types, defaults and helper functions for the Sobel result writer
//
// Purpose: state encoding, default geometry/width parameters, the gradient
//          saturation function and the interior-pixel range check used by
//          sobel_result_writer and sobel_frame_buf.
// Ports:   none (package).
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int IMG_WIDTH_DEF  = 8;
  localparam int IMG_HEIGHT_DEF = 8;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int COORD_W_DEF    = 3;
  localparam int THRESHOLD_DEF  = 128;

  // Clamp v to the largest value representable in dw bits. The caller
  // narrows the 32-bit result to its own width.
  function automatic logic [31:0] sat_val(input logic [31:0] v, input int dw);
    logic [31:0] max_v;
    max_v = (32'd1 << dw) - 32'd1;
    return (v > max_v) ? max_v : v;
  endfunction

  // True when (row, col) is off the one-pixel border of a w x h frame.
  function automatic logic is_interior(input int row, input int col,
                                       input int w, input int h);
    return (row >= 1) && (row <= h - 2) && (col >= 1) && (col <= w - 2);
  endfunction

endpackage

// File: rtl/sobel_frame_buf.sv
// rtl/sobel_frame_buf.sv - interior-pixel frame store with a written-mask
//
// Purpose: (IMG_WIDTH-2)*(IMG_HEIGHT-2) register storage for interior results.
//          Synchronous write, combinational read addressed by frame (x, y).
// Ports:   clk, rst         clock, asynchronous active-high reset (mask only)
//          clear            clear every mask bit on the next edge
//          wr_en            store wr_data at (wr_row, wr_col); caller guarantees interior
//          wr_row, wr_col   write coordinates in frame space
//          wr_data          value to store (SW bits)
//          rd_x, rd_y       read coordinates in frame space
//          rd_written       1 when (rd_x, rd_y) is interior and has been written
//          rd_data          stored value at (rd_x, rd_y); meaningful only with rd_written
module sobel_frame_buf
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int COORD_W    = COORD_W_DEF,
  parameter int SW         = DATA_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [COORD_W-1:0] wr_row,
  input  logic [COORD_W-1:0] wr_col,
  input  logic [SW-1:0]      wr_data,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  output logic               rd_written,
  output logic [SW-1:0]      rd_data
);

  localparam int IW = IMG_WIDTH - 2;
  localparam int N  = IW * (IMG_HEIGHT - 2);
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  mask_q, mask_d;
  logic [SW-1:0] mem_q [N];
  logic [SW-1:0] mem_d [N];
  logic [AW-1:0] wr_idx, rd_idx;
  logic          rd_in;

  // Linear index of the interior location; border reads are pinned to entry 0
  // and masked off through rd_in.
  always_comb begin
    wr_idx = AW'((int'(wr_row) - 1) * IW + (int'(wr_col) - 1));
    rd_in  = is_interior(int'(rd_y), int'(rd_x), IMG_WIDTH, IMG_HEIGHT);
    rd_idx = rd_in ? AW'((int'(rd_y) - 1) * IW + (int'(rd_x) - 1)) : '0;
  end

  always_comb begin
    mask_d = mask_q;
    mem_d  = mem_q;
    if (clear) begin
      mask_d = '0;
    end else if (wr_en) begin
      mask_d[wr_idx] = 1'b1;
      mem_d[wr_idx]  = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end

  // Contents need no reset: an entry is only ever read behind its mask bit.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_written = rd_in & mask_q[rd_idx];
  assign rd_data    = mem_q[rd_idx];

endmodule

// File: rtl/sobel_result_writer.sv
// rtl/sobel_result_writer.sv - collects Sobel results and drains a full frame in raster order
//
// Purpose: captures (row, col, gradient) results into an interior frame store,
//          then on frame_done streams IMG_WIDTH x IMG_HEIGHT pixels over a
//          valid/ready interface. Border and unwritten pixels emit 0; gradients
//          saturate to DATA_WIDTH bits.
// Build option: SOBEL_WRITER_BINARY_EN - when defined, stores one bit per
//          interior pixel (sat(in_data) >= THRESHOLD) and emits all-ones or 0.
// Ports:   clk, rst                       clock, asynchronous active-high reset
//          start                          begin a new frame (IDLE only)
//          in_valid, in_row, in_col, in_data  result strobe and payload
//          frame_done                     engine finished the frame (COLLECT only)
//          busy                           high in COLLECT or DRAIN
//          out_valid, out_ready           output handshake
//          out_data, out_x, out_y         output pixel and its coordinates
//          out_last                       high with pixel (IMG_WIDTH-1, IMG_HEIGHT-1)
//          drop_err                       sticky: a result was discarded
module sobel_result_writer
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int COORD_W    = COORD_W_DEF,
  parameter int THRESHOLD  = THRESHOLD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [COORD_W-1:0]    in_row,
  input  logic [COORD_W-1:0]    in_col,
  input  logic [DATA_WIDTH+2:0] in_data,
  input  logic                  frame_done,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [COORD_W-1:0]    out_x,
  output logic [COORD_W-1:0]    out_y,
  output logic                  out_last,
  output logic                  drop_err
);

`ifdef SOBEL_WRITER_BINARY_EN
  localparam int SW = 1;
`else
  localparam int SW = DATA_WIDTH;
`endif

  localparam logic [DATA_WIDTH-1:0] PIX_MAX = '1;
  localparam logic [COORD_W-1:0]    X_MAX   = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0]    Y_MAX   = COORD_W'(IMG_HEIGHT - 1);

  if (IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_size
    $error("sobel_result_writer: frame must be at least 3x3");
  end
  if ((1 << COORD_W) < IMG_WIDTH || (1 << COORD_W) < IMG_HEIGHT) begin : g_bad_coord
    $error("sobel_result_writer: COORD_W too narrow for frame size");
  end
  if (THRESHOLD < 0 || THRESHOLD > (1 << DATA_WIDTH)) begin : g_bad_thr
    $error("sobel_result_writer: THRESHOLD out of range");
  end

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  drop_err_q, drop_err_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [COORD_W-1:0]    out_x_q, out_x_d;
  logic [COORD_W-1:0]    out_y_q, out_y_d;

  logic [COORD_W-1:0]    rd_x, rd_y;
  logic                  in_interior, wr_en, buf_clear, rd_written;
  logic [DATA_WIDTH-1:0] sat_in, pix;
  logic [SW-1:0]         wr_data, rd_data;

  assign in_interior = is_interior(int'(in_row), int'(in_col), IMG_WIDTH, IMG_HEIGHT);
  assign wr_en       = (state_q == COLLECT) && in_valid && in_interior;
  assign buf_clear   = (state_q == IDLE) && start;

  always_comb begin
    sat_in = DATA_WIDTH'(sat_val(32'(in_data), DATA_WIDTH));
`ifdef SOBEL_WRITER_BINARY_EN
    wr_data = (32'(sat_in) >= THRESHOLD) ? 1'b1 : 1'b0;
    pix     = (rd_written && rd_data[0]) ? PIX_MAX : '0;
`else
    wr_data = sat_in;
    pix     = rd_written ? rd_data : '0;
`endif
  end

  sobel_frame_buf #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .COORD_W    (COORD_W),
    .SW         (SW)
  ) u_frame_buf (
    .clk        (clk),
    .rst        (rst),
    .clear      (buf_clear),
    .wr_en      (wr_en),
    .wr_row     (in_row),
    .wr_col     (in_col),
    .wr_data    (wr_data),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_written (rd_written),
    .rd_data    (rd_data)
  );

  // rd_x/rd_y are the coordinates of the pixel presented next cycle; the
  // output registers load the frame-store read at those coordinates.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    drop_err_d  = drop_err_q;
    rd_x        = out_x_q;
    rd_y        = out_y_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = COLLECT;
          drop_err_d = 1'b0;
        end
      end
      COLLECT: begin
        if (frame_done) begin
          state_d     = DRAIN;
          out_valid_d = 1'b1;
          rd_x        = '0;
          rd_y        = '0;
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end else if (out_x_q == X_MAX) begin
            rd_x = '0;
            rd_y = out_y_q + COORD_W'(1);
          end else begin
            rd_x = out_x_q + COORD_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Set after the start clear so a same-cycle discard is not lost.
    if (in_valid && !((state_q == COLLECT) && in_interior)) drop_err_d = 1'b1;

    out_x_d    = rd_x;
    out_y_d    = rd_y;
    out_data_d = pix;
    out_last_d = out_valid_d && (rd_x == X_MAX) && (rd_y == Y_MAX);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      drop_err_q  <= 1'b0;
      out_data_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      drop_err_q  <= drop_err_d;
      out_data_q  <= out_data_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign drop_err  = drop_err_q;
  assign out_data  = out_data_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

endmodule

// File: tb/tb_sobel_result_writer.sv
// tb/tb_sobel_result_writer.sv - self-checking bench for sobel_result_writer
//
// Purpose: drives random and directed frames, models the expected drained
//          frame with plain arrays, and compares every output beat.
// Ports:   none (top-level bench).
module tb_sobel_result_writer;

  localparam int W   = 8;
  localparam int H   = 8;
  localparam int DW  = 8;
  localparam int CW  = 3;
  localparam int THR = 128;
  localparam int MAXV = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_row = '0;
  logic [CW-1:0] in_col = '0;
  logic [DW+2:0] in_data = '0;
  logic          frame_done = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, out_valid, out_last, drop_err;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_x, out_y;

  int total = 0;
  int bad   = 0;

  int mdl_val [H][W];
  bit mdl_wr  [H][W];

  int beat_d[$];
  int beat_x[$];
  int beat_y[$];
  int beat_l[$];
  int hold_viol;
  int drain_cycles;
  bit timed_out;

  sobel_result_writer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_WIDTH (DW),
    .COORD_W    (CW),
    .THRESHOLD  (THR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_row     (in_row),
    .in_col     (in_col),
    .in_data    (in_data),
    .frame_done (frame_done),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_last   (out_last),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected pixel straight from the behavioural rules.
  function automatic int expect_px(input int x, input int y);
    if (x < 1 || x > W - 2 || y < 1 || y > H - 2 || !mdl_wr[y][x]) return 0;
`ifdef SOBEL_WRITER_BINARY_EN
    return (mdl_val[y][x] >= THR) ? MAXV : 0;
`else
    return mdl_val[y][x];
`endif
  endfunction

  task automatic model_clear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) mdl_wr[y][x] = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    model_clear();
  endtask

  task automatic do_write(input int r, input int c, input int v, input bit collecting);
    in_valid = 1'b1;
    in_row   = CW'(r);
    in_col   = CW'(c);
    in_data  = (DW + 3)'(v);
    cyc();
    in_valid = 1'b0;
    if (collecting && r >= 1 && r <= H - 2 && c >= 1 && c <= W - 2) begin
      mdl_val[r][c] = (v > MAXV) ? MAXV : v;
      mdl_wr[r][c]  = 1'b1;
    end
  endtask

  task automatic do_frame_done();
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
  endtask

  // Collects accepted beats; stop_after > 0 leaves the stream mid-frame.
  task automatic drain(input bit rnd, input int stop_after);
    logic          pv, pr, pl;
    logic [DW-1:0] pd;
    logic [CW-1:0] px, py;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; px = '0; py = '0;
    beat_d.delete(); beat_x.delete(); beat_y.delete(); beat_l.delete();
    hold_viol = 0; drain_cycles = 0; timed_out = 1'b0;
    forever begin
      if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd || out_x !== px ||
                        out_y !== py || out_last !== pl)) hold_viol++;
      if (stop_after > 0 && beat_d.size() == stop_after) begin
        out_ready = 1'b0;
        return;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pv = out_valid; pr = out_ready; pd = out_data; px = out_x; py = out_y; pl = out_last;
      cyc();
      drain_cycles++;
      if (pv && pr) begin
        beat_d.push_back(int'(pd));
        beat_x.push_back(int'(px));
        beat_y.push_back(int'(py));
        beat_l.push_back(int'(pl));
        if (pl) break;
      end
      if (drain_cycles > 2000) begin
        timed_out = 1'b1;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL reset_drop_err got=%b exp=0", drop_err); end
    total++; if (out_data !== '0 || out_x !== '0 || out_y !== '0) begin
      bad++; $display("FAIL reset_outputs got d=%0d x=%0d y=%0d exp 0 0 0", out_data, out_x, out_y);
    end
    rst = 1'b0;
    cyc();
    model_clear();
  endtask

  task automatic test_full_frame();
    do_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy_rise got=%b exp=1", busy); end
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++) do_write(r, c, r * 10 + c, 1'b1);
    do_frame_done();
    total++; if (out_valid !== 1'b1 || out_x !== '0 || out_y !== '0) begin
      bad++; $display("FAIL full_drain_entry got v=%b x=%0d y=%0d exp v=1 x=0 y=0", out_valid, out_x, out_y);
    end
    drain(1'b0, 0);
    total++; if (timed_out || beat_d.size() != W * H) begin
      bad++; $display("FAIL full_count got=%0d exp=%0d", beat_d.size(), W * H);
    end
    total++; if (drain_cycles != W * H) begin
      bad++; $display("FAIL full_rate got=%0d cycles exp=%0d", drain_cycles, W * H);
    end
    for (int i = 0; i < beat_d.size() && i < W * H; i++) begin
      total++;
      if (beat_x[i] != i % W || beat_y[i] != i / W || beat_d[i] != expect_px(i % W, i / W) ||
          beat_l[i] != int'(i == W * H - 1)) begin
        bad++;
        $display("FAIL full_beat%0d got x=%0d y=%0d d=%0d l=%0d exp x=%0d y=%0d d=%0d l=%0d",
                 i, beat_x[i], beat_y[i], beat_d[i], beat_l[i], i % W, i / W,
                 expect_px(i % W, i / W), int'(i == W * H - 1));
      end
    end
`ifndef SOBEL_WRITER_BINARY_EN
    total++; if (beat_d.size() > 26 && beat_d[26] != 32) begin
      bad++; $display("FAIL full_px32 got=%0d exp=32", beat_d[26]);
    end
`endif
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL full_end got v=%b busy=%b exp 0 0", out_valid, busy);
    end
  endtask

  task automatic test_saturation();
    int exp127, exp128, exp255;
`ifdef SOBEL_WRITER_BINARY_EN
    exp127 = 0; exp128 = MAXV; exp255 = MAXV;
`else
    exp127 = 127; exp128 = 128; exp255 = 255;
`endif
    do_start();
    for (int k = 0; k < 20; k++)
      do_write($urandom_range(1, H - 2), $urandom_range(1, W - 2), $urandom_range(0, 2047), 1'b1);
    do_write(1, 1, 700, 1'b1);
    do_write(1, 2, 255, 1'b1);
    do_write(1, 3, 0, 1'b1);
    do_write(1, 4, 127, 1'b1);
    do_write(1, 5, 128, 1'b1);
    do_frame_done();
    drain(1'b0, 0);
    total++; if (timed_out || beat_d.size() != W * H) begin
      bad++; $display("FAIL sat_count got=%0d exp=%0d", beat_d.size(), W * H);
    end
    if (beat_d.size() == W * H) begin
      total++; if (beat_d[9] != MAXV)   begin bad++; $display("FAIL sat_700 got=%0d exp=%0d", beat_d[9], MAXV); end
      total++; if (beat_d[10] != exp255) begin bad++; $display("FAIL sat_255 got=%0d exp=%0d", beat_d[10], exp255); end
      total++; if (beat_d[11] != 0)      begin bad++; $display("FAIL sat_0 got=%0d exp=0", beat_d[11]); end
      total++; if (beat_d[12] != exp127) begin bad++; $display("FAIL thr_127 got=%0d exp=%0d", beat_d[12], exp127); end
      total++; if (beat_d[13] != exp128) begin bad++; $display("FAIL thr_128 got=%0d exp=%0d", beat_d[13], exp128); end
      for (int i = 0; i < W * H; i++) begin
        total++;
        if (beat_d[i] != expect_px(i % W, i / W)) begin
          bad++; $display("FAIL sat_beat%0d got=%0d exp=%0d", i, beat_d[i], expect_px(i % W, i / W));
        end
      end
    end
  endtask

  task automatic test_mask_clear();
    int nz;
    do_start();
    do_write(4, 4, 90, 1'b1);
    do_frame_done();
    drain(1'b0, 0);
    nz = 0;
    for (int i = 0; i < beat_d.size(); i++) if (i != 4 * W + 4 && beat_d[i] != 0) nz++;
    total++; if (timed_out || beat_d.size() != W * H || nz != 0) begin
      bad++; $display("FAIL single_others got beats=%0d nonzero=%0d exp beats=%0d nonzero=0", beat_d.size(), nz, W * H);
    end
    total++; if (beat_d.size() == W * H && beat_d[4 * W + 4] != expect_px(4, 4)) begin
      bad++; $display("FAIL single_px got=%0d exp=%0d", beat_d[4 * W + 4], expect_px(4, 4));
    end
    do_start();
    do_frame_done();
    drain(1'b0, 0);
    nz = 0;
    for (int i = 0; i < beat_d.size(); i++) if (beat_d[i] != 0) nz++;
    total++; if (timed_out || beat_d.size() != W * H || nz != 0) begin
      bad++; $display("FAIL mask_clear got beats=%0d nonzero=%0d exp beats=%0d nonzero=0", beat_d.size(), nz, W * H);
    end
  endtask

  task automatic test_backpressure();
    do_start();
    for (int k = 0; k < 50; k++)
      do_write($urandom_range(1, H - 2), $urandom_range(1, W - 2), $urandom_range(0, 1023), 1'b1);
    do_frame_done();
    drain(1'b1, 0);
    total++; if (timed_out || beat_d.size() != W * H) begin
      bad++; $display("FAIL bp_count got=%0d exp=%0d", beat_d.size(), W * H);
    end
    total++; if (hold_viol != 0) begin
      bad++; $display("FAIL bp_hold got=%0d violations exp=0", hold_viol);
    end
    for (int i = 0; i < beat_d.size() && i < W * H; i++) begin
      total++;
      if (beat_x[i] != i % W || beat_y[i] != i / W || beat_d[i] != expect_px(i % W, i / W)) begin
        bad++;
        $display("FAIL bp_beat%0d got x=%0d y=%0d d=%0d exp x=%0d y=%0d d=%0d",
                 i, beat_x[i], beat_y[i], beat_d[i], i % W, i / W, expect_px(i % W, i / W));
      end
    end
  endtask

  task automatic test_drop();
    do_start();
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL drop_start got=%b exp=0", drop_err); end
    do_write(2, 2, 5, 1'b1);
    do_write(0, 3, 99, 1'b1);
    total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL drop_border got=%b exp=1", drop_err); end
    do_write(7, 7, 99, 1'b1);
    do_frame_done();
    do_write(2, 2, 200, 1'b0);
    drain(1'b0, 0);
    total++; if (timed_out || beat_d.size() != W * H) begin
      bad++; $display("FAIL drop_count got=%0d exp=%0d", beat_d.size(), W * H);
    end
    if (beat_d.size() == W * H) begin
      total++; if (beat_d[2 * W + 2] != expect_px(2, 2)) begin
        bad++; $display("FAIL drop_keep got=%0d exp=%0d", beat_d[2 * W + 2], expect_px(2, 2));
      end
      total++; if (beat_d[3] != 0 || beat_d[W * H - 1] != 0) begin
        bad++; $display("FAIL drop_discard got=%0d,%0d exp=0,0", beat_d[3], beat_d[W * H - 1]);
      end
    end
    do_write(3, 3, 9, 1'b0);
    total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL drop_idle got=%b exp=1", drop_err); end
    do_start();
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL drop_clear got=%b exp=0", drop_err); end
    do_frame_done();
    drain(1'b0, 0);
  endtask

  task automatic test_reset_mid_drain();
    int nz;
    do_start();
    for (int k = 0; k < 15; k++)
      do_write($urandom_range(1, H - 2), $urandom_range(1, W - 2), $urandom_range(1, 2047), 1'b1);
    do_frame_done();
    drain(1'b0, 20);
    total++; if (beat_d.size() != 20) begin bad++; $display("FAIL rstmid_beats got=%0d exp=20", beat_d.size()); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_x !== '0 || out_y !== '0) begin
      bad++; $display("FAIL rstmid_async got v=%b busy=%b x=%0d y=%0d exp 0 0 0 0", out_valid, busy, out_x, out_y);
    end
    cyc();
    rst = 1'b0;
    model_clear();
    cyc();
    do_start();
    do_frame_done();
    drain(1'b0, 0);
    nz = 0;
    for (int i = 0; i < beat_d.size(); i++) if (beat_d[i] != 0) nz++;
    total++; if (timed_out || beat_d.size() != W * H || nz != 0) begin
      bad++; $display("FAIL rstmid_after got beats=%0d nonzero=%0d exp beats=%0d nonzero=0", beat_d.size(), nz, W * H);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_saturation();
    test_mask_clear();
    test_backpressure();
    test_drop();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
